// File: rtl/apb_req_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : apb_req_arbiter
// Description : Shares one APB register slave between NREQ internal requesters.
//               One request is accepted at a time through valid/ready
//               handshakes. Each transfer runs SETUP then ACCESS, with an
//               extra RDATA cycle for reads, and a one-hot response pulse is
//               returned to the requester that issued it. The slave has no
//               PREADY, so every transfer has a fixed length.
// Options     : APB_ARB_FIXED_PRIO_EN - when defined, the lowest requester
//               index always wins and no last-grant pointer exists. When
//               undefined, arbitration is round-robin.
// Revision    : 1.0 - initial release
//==============================================================================
module apb_req_arbiter #(
    parameter int NREQ  = 4,
    parameter int ADDRW = 8,
    parameter int DATAW = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_write,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    input  logic [NREQ*DATAW-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [DATAW-1:0]      rsp_rdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDRW-1:0]      paddr,
    output logic [DATAW-1:0]      pwdata,
    input  logic [DATAW-1:0]      prdata
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RDATA  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            arb_cycle;
    logic            any_valid;
    logic            grant;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] gnt_idx;

    // A write's ACCESS cycle doubles as the next arbitration cycle, which is
    // what gives back-to-back writes their two-cycle spacing.
    assign arb_cycle = (state == ST_IDLE) ||
                       (state == ST_RDATA) ||
                       ((state == ST_ACCESS) && pwrite);
    assign any_valid = |req_valid;
    // Gating with rst_n keeps req_ready low while reset is held.
    assign grant     = arb_cycle && any_valid && rst_n;

`ifdef APB_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest pending index wins.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_idx = IDXW'(k);
            end
        end
    end
`else
    logic [IDXW-1:0] last_gnt;
    logic            rr_found;
    int              cand;

    // Round-robin: search from last_gnt+1 upward, wrapping modulo NREQ.
    always_comb begin
        win_idx  = last_gnt;
        rr_found = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_gnt) + k) % NREQ;
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                win_idx  = IDXW'(cand);
            end
        end
    end

    // Last-grant pointer moves only when a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= IDXW'(NREQ - 1);
        end else if (grant) begin
            last_gnt <= win_idx;
        end
    end
`endif

    // One-hot acceptance strobe for the winner of this arbitration cycle.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and APB phase outputs.
    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = grant ? ST_SETUP : ST_IDLE;
            end
            ST_SETUP: begin
                psel      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pwrite) begin
                    state_nxt = grant ? ST_SETUP : ST_IDLE;
                end else begin
                    state_nxt = ST_RDATA;
                end
            end
            ST_RDATA: begin
                state_nxt = grant ? ST_SETUP : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's payload; the APB bus holds it until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            gnt_idx <= '0;
        end else if (grant) begin
            paddr   <= req_addr[win_idx*ADDRW +: ADDRW];
            pwrite  <= req_write[win_idx];
            pwdata  <= req_wdata[win_idx*DATAW +: DATAW];
            gnt_idx <= win_idx;
        end
    end

    // Completion pulse: after a write's ACCESS, or after a read's RDATA cycle
    // where prdata is captured. rsp_rdata is zero whenever no read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            if ((state == ST_ACCESS) && pwrite) begin
                rsp_valid[gnt_idx] <= 1'b1;
            end
            if (state == ST_RDATA) begin
                rsp_valid[gnt_idx] <= 1'b1;
                rsp_rdata          <= prdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_apb_req_arbiter
// Description : Directed testbench for apb_req_arbiter with an APB slave
//               model and a response scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_apb_req_arbiter;

    localparam int NREQ  = 4;
    localparam int ADDRW = 8;
    localparam int DATAW = 32;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_write;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*DATAW-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [DATAW-1:0]      rsp_rdata;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDRW-1:0]      paddr;
    logic [DATAW-1:0]      pwdata;
    logic [DATAW-1:0]      prdata;

    apb_req_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // APB slave: registered read data, presented during the RDATA cycle.
    logic [DATAW-1:0] mem    [256];
    logic [DATAW-1:0] shadow [256];
    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k]    = '0;
            shadow[k] = '0;
        end
        mem[8'h20]    = 32'hCAFE_F00D;
        shadow[8'h20] = 32'hCAFE_F00D;
        prdata        = 32'hA5A5_A5A5;
    end
    always @(posedge clk) begin
        if (psel && penable) begin
            if (pwrite) mem[paddr] <= pwdata;
            else        prdata     <= mem[paddr];
        end
    end

    // Scoreboard: an entry is pushed at acceptance and popped at completion.
    typedef struct {
        int               idx;
        bit               wr;
        logic [DATAW-1:0] rdata;
        int               cyc;
    } sb_t;
    sb_t             sb [$];
    sb_t             e_in;
    sb_t             e_out;
    int              mon_idx;
    logic [ADDRW-1:0] mon_a;
    logic [NREQ-1:0] last_ready = '0;

    always @(negedge clk) begin
        last_ready = rst_n ? req_ready : '0;
        if (rst_n) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    e_out = sb.pop_front();
                    chk("sb_rsp_who", 64'(rsp_valid), 64'(1 << e_out.idx));
                    chk("sb_rsp_rdata", 64'(rsp_rdata), 64'(e_out.rdata));
                    chk("sb_rsp_latency", 64'(cyc - e_out.cyc), e_out.wr ? 64'd3 : 64'd4);
                end
            end else begin
                chk("rdata_idle_zero", 64'(rsp_rdata), 64'd0);
            end
            if (req_ready != '0) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                mon_idx = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) mon_idx = k;
                mon_a      = req_addr[mon_idx*ADDRW +: ADDRW];
                e_in.idx   = mon_idx;
                e_in.wr    = req_write[mon_idx];
                e_in.cyc   = cyc;
                if (e_in.wr) begin
                    e_in.rdata    = '0;
                    shadow[mon_a] = req_wdata[mon_idx*DATAW +: DATAW];
                end else begin
                    e_in.rdata = shadow[mon_a];
                end
                sb.push_back(e_in);
            end
        end
    end

    // Advance one cycle; accepted requesters drop their valid as a real
    // requester would.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_ready;
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [ADDRW-1:0] a,
                           input logic [DATAW-1:0] d);
        req_write[i]                = wr;
        req_addr[i*ADDRW +: ADDRW]  = a;
        req_wdata[i*DATAW +: DATAW] = d;
        req_valid[i]                = 1'b1;
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_psel"},      64'(psel),      64'd0);
        chk({pfx, "_penable"},   64'(penable),   64'd0);
        chk({pfx, "_pwrite"},    64'(pwrite),    64'd0);
        chk({pfx, "_paddr"},     64'(paddr),     64'd0);
        chk({pfx, "_pwdata"},    64'(pwdata),    64'd0);
        chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        set_req(0, 1'b1, 8'h10, 32'h1);
        #1;
        tick();
        tick();
        chk_reset("por");
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Single write then read back by requester 0.
        tick();
        set_req(0, 1'b1, 8'h10, 32'hDEAD_BEEF); #1;
        chk("wr_ready", 64'(req_ready), 64'h1);
        tick();
        chk("wr_setup", 64'({psel, penable}), 64'b10);
        chk("wr_paddr", 64'(paddr), 64'h10);
        chk("wr_pwrite", 64'(pwrite), 64'd1);
        chk("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
        tick();
        chk("wr_access", 64'({psel, penable}), 64'b11);
        tick();
        chk("wr_rsp", 64'(rsp_valid), 64'h1);
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("wr_idle_psel", 64'(psel), 64'd0);
        set_req(0, 1'b0, 8'h10, 32'h0); #1;
        chk("rd_ready", 64'(req_ready), 64'h1);
        tick();
        tick();
        chk("rd_access", 64'({psel, penable}), 64'b11);
        chk("rd_access_pwrite", 64'(pwrite), 64'd0);
        tick();
        chk("rd_rdata_phase", 64'({psel, penable}), 64'b00);
        tick();
        chk("rd_rsp", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);

        // Requester 1 reads while requester 2 waits with a write.
        set_req(1, 1'b0, 8'h20, 32'h0);
        set_req(2, 1'b1, 8'h30, 32'h1234_5678); #1;
        chk("mix_ready_r1", 64'(req_ready), 64'h2);
        tick();
        chk("mix_setup_noready", 64'(req_ready), 64'h0);
        tick();
        chk("mix_access_noready", 64'(req_ready), 64'h0);
        tick();
        chk("mix_rdata_ready_r2", 64'(req_ready), 64'h4);
        tick();
        chk("mix_rd_rsp", 64'(rsp_valid), 64'h2);
        chk("mix_rd_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
        tick();
        tick();
        chk("mix_wr_rsp", 64'(rsp_valid), 64'h4);

        // Round-robin wrap: after requester 3, requester 0 beats 2.
        set_req(3, 1'b1, 8'h40, 32'h44); #1;
        chk("rr_ready_r3", 64'(req_ready), 64'h8);
        tick();
        set_req(0, 1'b1, 8'h50, 32'h55);
        set_req(2, 1'b1, 8'h60, 32'h66); #1;
        chk("rr_midxfer_wait", 64'(req_ready), 64'h0);
        tick();
        chk("rr_wrap_r0", 64'(req_ready), 64'h1);
        tick();
        tick();
        chk("rr_then_r2", 64'(req_ready), 64'h4);
        tick();
        tick();
        chk("rr_last_access_noready", 64'(req_ready), 64'h0);
        tick();

        // Idle hold after the last write.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_psel", 64'(psel), 64'd0);
            chk("idle_paddr", 64'(paddr), 64'h60);
            chk("idle_pwdata", 64'(pwdata), 64'h66);
            chk("idle_ready", 64'(req_ready), 64'h0);
        end

        // Reset during the ACCESS phase of a read.
        set_req(1, 1'b0, 8'h20, 32'h0); #1;
        chk("rst_rd_ready", 64'(req_ready), 64'h2);
        tick();
        tick();
        chk("rst_rd_access", 64'({psel, penable}), 64'b11);
        set_req(3, 1'b1, 8'h70, 32'h77);
        rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        sb.delete();
        tick();
        tick();
        chk("rst_no_rsp", 64'(rsp_valid), 64'h0);

        // After release: all four write at once, requester 0 first.
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i), 32'(i + 1));
        #1;
        chk("all_grant0", 64'(req_ready), 64'h1);
        tick();
        chk("all_setup_noready", 64'(req_ready), 64'h0);
        tick();
        chk("all_grant1", 64'(req_ready), 64'h2);
        tick();
        chk("all_rsp0", 64'(rsp_valid), 64'h1);
        tick();
        chk("all_grant2", 64'(req_ready), 64'h4);
        tick();
        tick();
        chk("all_grant3", 64'(req_ready), 64'h8);
        tick();
        tick();
        tick();
        set_req(3, 1'b0, 8'h03, 32'h0); #1;
        chk("readback_ready", 64'(req_ready), 64'h8);

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("drain_empty", 64'(sb.size()), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
